md_unit_e: RTL and testbench
============================

// Module: md_unit_e
// PURPOSE
//   EX-stage multiply/divide unit consuming the decoded operands and md controls leaving the ID/EX register.
//   Holds architectural HI/LO, runs mult/multu/div/divu as a multi-cycle operation and reads/writes HI/LO for mfhi/mflo/mthi/mtlo.
//   Returns md_stall toward ID so the hazard logic freezes PC/IF-ID and flushes ID/EX while an md instruction waits.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//   clk        in   1   single clock, all state on posedge
//   reset      in   1   synchronous, active-high
//   md_startE  in   1   EX instr is mult/multu/div/divu (0 when ID/EX flushed)
//   md_opE     in   2   00 mult, 01 multu, 10 div, 11 divu
//   md_wrE     in   2   00 none, 01 mthi, 10 mtlo, 11 reserved (ignored)
//   srcAE      in   32  forwarded rs value (dividend / multiplicand / mt data)
//   srcBE      in   32  forwarded rt value (divisor / multiplier)
//   md_useD    in   1   instr in ID is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo
//   hi         out  32  architectural HI
//   lo         out  32  architectural LO
//   busy       out  1   operation in progress
//   md_stall   out  1   stall request to ID: md_useD & (md_startE | busy)
// BEHAVIOUR
//   - Reset: hi=0, lo=0, busy=0, counter=0, state IDLE; reset mid-operation aborts it, pending result discarded.
//   - States: IDLE, RUN. IDLE -> RUN on md_startE; RUN -> IDLE when counter==1 at an edge.
//   - Start accepted only in IDLE: operands and result computed and held in pending_hi/pending_lo at
//     edge t; counter loaded with MULT_CYCLES or DIV_CYCLES; busy=1 for cycles t+1..t+N.
//   - At edge ending cycle t+N: hi/lo <- pending, busy->0. New hi/lo visible from cycle t+N+1.
//   - md_startE while RUN: ignored (cannot occur under correct stall; bench checks no corruption).
//   - mult: signed 64-bit product; multu: unsigned; {hi,lo} = product.
//   - div: lo=quotient truncated toward zero, hi=remainder with sign of dividend; divu unsigned.
//   - div/divu by zero: busy still runs DIV_CYCLES, hi/lo unchanged at completion.
//   - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
//   - mthi/mtlo: in IDLE, hi or lo <- srcAE at next edge; ignored while RUN; md_wrE=11 ignored.
//   - md_startE and md_wrE!=0 same cycle: start wins, write dropped.
//   - hi/lo outputs are registers (mfhi/mflo read them combinationally in EX; no internal bypass of pending values).
//   - md_stall combinational; asserted in cycle t (start in EX) through t+N when md_useD=1, deasserted
//     in cycle t+N+1 so the waiting instr enters EX seeing final hi/lo.
//   - Non-md instructions never stalled by this block.
// TESTING
//   1. reset held 2 cycles mid-div -> hi=lo=0, busy=0 next cycle; no late hi/lo update afterwards.
//   2. mult 0xFFFFFFFE x 0x00000003, md_useD=1 (mflo) -> busy cycles 1-5, md_stall 0-5,
//      hi=0xFFFFFFFF lo=0xFFFFFFFA at cycle 6; multu same operands -> hi=0x2 lo=0xFFFFFFFA.
//   3. div 0xFFFFFFF9(-7) / 2 -> after 10 busy cycles lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1);
//      divu 7/2 -> lo=3, hi=1.
//   4. hi=0x11,lo=0x22 via mthi/mtlo, then div x/0 -> busy 10 cycles, hi=0x11 lo=0x22 unchanged;
//      div 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
//   5. mthi 0xDEAD while busy -> ignored; start during RUN -> ignored, original result lands on time.
//   6. md_useD=0 throughout mult -> md_stall never asserts, busy still 5 cycles.

Source files
------------

// File: rtl/md_unit_e_if.sv
// rtl/md_unit_e_if.sv - EX-stage multiply/divide unit interface
interface md_unit_e_if;
   logic        md_startE;
   logic [1:0]  md_opE;
   logic [1:0]  md_wrE;
   logic [31:0] srcAE;
   logic [31:0] srcBE;
   logic        md_useD;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        md_stall;

   modport master (
      output md_startE, md_opE, md_wrE, srcAE, srcBE, md_useD,
      input  hi, lo, busy, md_stall
   );

   modport slave (
      input  md_startE, md_opE, md_wrE, srcAE, srcBE, md_useD,
      output hi, lo, busy, md_stall
   );
endinterface

// File: rtl/md_unit_e.sv
// rtl/md_unit_e.sv - EX-stage multi-cycle multiply/divide unit with HI/LO
module md_unit_e #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic        clk,
   input logic        reset,
   md_unit_e_if.slave bus
);
   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [CW-1:0] counter;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;
   logic [31:0]   pending_hi;
   logic [31:0]   pending_lo;
   logic          pending_valid;
   logic          busy_q;

   logic [63:0]   next_result;
   logic          next_valid;
   logic [31:0]   quo;
   logic [31:0]   rem;

   // Result of the operation presented in EX; computed up front and held until the busy window ends.
   // A zero divisor marks the result invalid so HI/LO survive the division untouched.
   always_comb begin
      next_result = '0;
      next_valid  = 1'b1;
      quo         = '0;
      rem         = '0;
      case (bus.md_opE)
         2'b00: next_result = {{32{bus.srcAE[31]}}, bus.srcAE} * {{32{bus.srcBE[31]}}, bus.srcBE};
         2'b01: next_result = {32'h0, bus.srcAE} * {32'h0, bus.srcBE};
         2'b10: begin
            if (bus.srcBE == 32'h0) begin
               next_valid = 1'b0;
            end else if (bus.srcAE == 32'h8000_0000 && bus.srcBE == 32'hFFFF_FFFF) begin
               // Most-negative / -1 wraps to itself with no remainder rather than trapping.
               next_result = {32'h0, 32'h8000_0000};
            end else begin
               quo         = $signed(bus.srcAE) / $signed(bus.srcBE);
               rem         = $signed(bus.srcAE) % $signed(bus.srcBE);
               next_result = {rem, quo};
            end
         end
         default: begin
            if (bus.srcBE == 32'h0) begin
               next_valid = 1'b0;
            end else begin
               quo         = bus.srcAE / bus.srcBE;
               rem         = bus.srcAE % bus.srcBE;
               next_result = {rem, quo};
            end
         end
      endcase
   end

   // IDLE/RUN sequencer: accepts a start or an mt write in IDLE, commits the pending result as RUN ends.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         counter       <= '0;
         hi_q          <= '0;
         lo_q          <= '0;
         pending_hi    <= '0;
         pending_lo    <= '0;
         pending_valid <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.md_startE) begin
                  // Start has priority over a same-cycle mthi/mtlo.
                  pending_hi    <= next_result[63:32];
                  pending_lo    <= next_result[31:0];
                  pending_valid <= next_valid;
                  counter       <= bus.md_opE[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                  busy_q        <= 1'b1;
                  state         <= RUN;
               end else if (bus.md_wrE == 2'b01) begin
                  hi_q <= bus.srcAE;
               end else if (bus.md_wrE == 2'b10) begin
                  lo_q <= bus.srcAE;
               end
            end
            RUN: begin
               // Starts and mt writes arriving here are dropped; the hazard logic should prevent them.
               if (counter == CW'(1)) begin
                  if (pending_valid) begin
                     hi_q <= pending_hi;
                     lo_q <= pending_lo;
                  end
                  counter <= '0;
                  busy_q  <= 1'b0;
                  state   <= IDLE;
               end else begin
                  counter <= counter - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.busy     = busy_q;
   assign bus.md_stall = bus.md_useD & (bus.md_startE | busy_q);
endmodule

// File: tb/tb_md_unit_e.sv
// tb/tb_md_unit_e.sv - self-checking bench for md_unit_e
module tb_md_unit_e;
   localparam int MULT_C = 5;
   localparam int DIV_C  = 10;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   logic [31:0] h_m, l_m;

   md_unit_e_if bus ();

   md_unit_e #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        use_d;
      logic [31:0] eh;
      logic [31:0] el;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain wide arithmetic on the architectural definitions.
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] ph, input logic [31:0] pl,
                                 output logic [31:0] rh, output logic [31:0] rl);
      longint      sa, sb, q, r;
      logic [63:0] p;
      rh = ph;
      rl = pl;
      case (op)
         2'd0: begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
            rh = p[63:32];
            rl = p[31:0];
         end
         2'd1: begin
            p  = {32'h0, a} * {32'h0, b};
            rh = p[63:32];
            rl = p[31:0];
         end
         2'd2: if (b != 0) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            rl = q[31:0];
            rh = r[31:0];
         end
         default: if (b != 0) begin
            rl = a / b;
            rh = a % b;
         end
      endcase
   endfunction

   // Issues one md op at cycle t and checks busy/stall over the whole window and HI/LO afterwards.
   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic use_d, input logic [31:0] eh,
                         input logic [31:0] el, input logic [1:0] wr);
      int n;
      n = op[1] ? DIV_C : MULT_C;
      bus.md_startE = 1'b1;
      bus.md_opE    = op;
      bus.srcAE     = a;
      bus.srcBE     = b;
      bus.md_wrE    = wr;
      bus.md_useD   = use_d;
      @(negedge clk);
      chk({name, " stall_t"}, {31'h0, bus.md_stall}, {31'h0, use_d});
      chk({name, " busy_t"}, {31'h0, bus.busy}, 32'h0);
      next_cycle();
      bus.md_startE = 1'b0;
      bus.md_wrE    = 2'b00;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         chk($sformatf("%s busy_c%0d", name, k), {31'h0, bus.busy}, 32'h1);
         chk($sformatf("%s stall_c%0d", name, k), {31'h0, bus.md_stall}, {31'h0, use_d});
         if (k == n) begin
            chk({name, " hi_hold"}, bus.hi, h_m);
            chk({name, " lo_hold"}, bus.lo, l_m);
         end
         next_cycle();
      end
      @(negedge clk);
      chk({name, " busy_end"}, {31'h0, bus.busy}, 32'h0);
      chk({name, " stall_end"}, {31'h0, bus.md_stall}, 32'h0);
      chk({name, " hi"}, bus.hi, eh);
      chk({name, " lo"}, bus.lo, el);
      h_m = eh;
      l_m = el;
      next_cycle();
      bus.md_useD = 1'b0;
   endtask

   task automatic mt_write(input logic [1:0] wr, input logic [31:0] v);
      bus.md_wrE = wr;
      bus.srcAE  = v;
      next_cycle();
      bus.md_wrE = 2'b00;
      if (wr == 2'b01) h_m = v;
      if (wr == 2'b10) l_m = v;
      @(negedge clk);
      chk("mt hi", bus.hi, h_m);
      chk("mt lo", bus.lo, l_m);
      next_cycle();
   endtask

   vec_t vecs [6];

   initial begin
      logic [31:0] rh, rl;
      logic [1:0]  op;
      logic [31:0] a, b;

      vecs[0] = '{2'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
      vecs[1] = '{2'd1, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA};
      vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{2'd3, 32'h0000_0007, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'h0000_0003};
      vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000};
      vecs[5] = '{2'd0, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0001, 32'h0000_0000};

      reset         = 1'b1;
      bus.md_startE = 1'b0;
      bus.md_opE    = 2'b00;
      bus.md_wrE    = 2'b00;
      bus.srcAE     = '0;
      bus.srcBE     = '0;
      bus.md_useD   = 1'b0;
      h_m = '0;
      l_m = '0;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk("rst hi", bus.hi, 32'h0);
      chk("rst lo", bus.lo, 32'h0);
      chk("rst busy", {31'h0, bus.busy}, 32'h0);
      bus.md_useD = 1'b1;
      #1;
      chk("rst stall", {31'h0, bus.md_stall}, 32'h0);
      bus.md_useD = 1'b0;
      next_cycle();

      for (int i = 0; i < 6; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_d,
                vecs[i].eh, vecs[i].el, 2'b00);

      mt_write(2'b01, 32'h11);
      mt_write(2'b10, 32'h22);
      mt_write(2'b11, 32'h99);
      run_op("div0", 2'd2, 32'h1234, 32'h0, 1'b1, 32'h11, 32'h22, 2'b00);
      run_op("divu0_wr", 2'd3, 32'h55, 32'h0, 1'b0, 32'h11, 32'h22, 2'b01);

      // mthi and a second start while RUN must both be dropped.
      bus.md_startE = 1'b1;
      bus.md_opE    = 2'd1;
      bus.srcAE     = 32'd7;
      bus.srcBE     = 32'd6;
      next_cycle();
      bus.md_startE = 1'b0;
      bus.md_wrE    = 2'b01;
      bus.srcAE     = 32'hDEAD;
      next_cycle();
      bus.md_wrE    = 2'b00;
      bus.md_startE = 1'b1;
      bus.md_opE    = 2'd2;
      bus.srcAE     = 32'd100;
      bus.srcBE     = 32'd3;
      next_cycle();
      bus.md_startE = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("inrun busy5", {31'h0, bus.busy}, 32'h1);
      chk("inrun hi5", bus.hi, 32'h11);
      next_cycle();
      @(negedge clk);
      chk("inrun busy6", {31'h0, bus.busy}, 32'h0);
      chk("inrun hi", bus.hi, 32'h0);
      chk("inrun lo", bus.lo, 32'd42);
      next_cycle();
      @(negedge clk);
      chk("inrun busy7", {31'h0, bus.busy}, 32'h0);
      h_m = 32'h0;
      l_m = 32'd42;
      next_cycle();

      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 2) == 0)
            mt_write($urandom_range(1, 2) == 1 ? 2'b01 : 2'b10, $urandom);
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: b = 32'($urandom_range(1, 9));
            2: b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         model(op, a, b, h_m, l_m, rh, rl);
         run_op($sformatf("rnd%0d", i), op, a, b, 1'($urandom_range(0, 1)), rh, rl, 2'b00);
      end

      // Reset held two cycles mid-division discards the pending result.
      bus.md_startE = 1'b1;
      bus.md_opE    = 2'd3;
      bus.srcAE     = 32'd100;
      bus.srcBE     = 32'd7;
      next_cycle();
      bus.md_startE = 1'b0;
      next_cycle();
      next_cycle();
      reset = 1'b1;
      next_cycle();
      @(negedge clk);
      chk("rmid busy", {31'h0, bus.busy}, 32'h0);
      chk("rmid hi", bus.hi, 32'h0);
      chk("rmid lo", bus.lo, 32'h0);
      next_cycle();
      reset = 1'b0;
      for (int k = 0; k < 12; k++) next_cycle();
      @(negedge clk);
      chk("rlate busy", {31'h0, bus.busy}, 32'h0);
      chk("rlate hi", bus.hi, 32'h0);
      chk("rlate lo", bus.lo, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
